ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the 5-stage pipeline: registers the ID→EX bus and executes ALU, shift, LUI and MFHI/MFLO ops.
- Issues data-SRAM requests for loads/stores so read data returns in MEM.
- Runs an iterative 32-cycle divider that writes internal HI/LO, stalling upstream while busy.
- Produces the 76-bit ex_to_mem_bus consumed by MEM.

Parameters:
- STALL_W, 6, width of stall bus; bit 2 = EX, bit 3 = MEM.
- ID_EX_W, 146, width of id_to_ex_bus.
- EX_MEM_W, 76, width of ex_to_mem_bus.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- stall  in  STALL_W  per-stage stop flags (1 = Stop)
- id_to_ex_bus  in  146  {pc[145:114], alu_op[113:110], src1[109:78], src2[77:46], st_data[45:14], data_ram_en[13], data_ram_wen[12:9], sel_rf_res[8], rf_we[7], rf_waddr[6:2], div_en[1], div_signed[0]}
- ex_to_mem_bus  out  76  {pc[75:44], data_ram_en[43], data_ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], ex_result[31:0]}
- data_sram_en  out  1  SRAM enable
- data_sram_wen  out  4  byte write enables
- data_sram_addr  out  32  address (= ex_result)
- data_sram_wdata  out  32  store data
- stallreq_for_ex  out  1  request to stop stages 0..2

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Input register, priority in this order:
  - rst → 0.
  - stall[2]=1 and stall[3]=0 → 0 (bubble).
  - stall[2]=0 → load id_to_ex_bus.
  - otherwise hold.
- Register 0 ⇒ every output 0; HI/LO reset to 0.
- alu_op encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLT (signed, result 0/1), 7 SLTU.
  - 8 SLL, 9 SRL, 10 SRA: value src2, amount src1[4:0].
  - 11 LUI = {src2[15:0], 16'h0}.
  - 12 MFHI, 13 MFLO: read HI/LO.
  - 14 MULT, 15 MULTU: optional, see below.
- All arithmetic is modulo 2^32, with no overflow trap.
- ex_result is combinational from the registered bus.
- ex_to_mem_bus forwards registered pc, data_ram_en, data_ram_wen, sel_rf_res, rf_we, rf_waddr plus ex_result.
- SRAM signals are combinational from the register:
  - data_sram_en = data_ram_en.
  - data_sram_wen = data_ram_wen.
  - data_sram_addr = ex_result (decoder supplies ADD for loads/stores).
  - data_sram_wdata = st_data.
- Divider FSM, states IDLE, RUN, DONE:
  - IDLE & div_en=1 → latch |src1|, |src2|, sign info; cnt=0; go RUN. stallreq=1.
  - RUN: one restoring shift-subtract step per cycle. cnt increments; after step 31 (32 cycles) go DONE. stallreq=1.
  - DONE: stallreq=0. When stall[2]=0, write LO=quotient, HI=remainder and go IDLE. If stall[2]=1, hold DONE.
  - div_en=0 → stays IDLE, stallreq=0.
  - Total stall for one div: 33 cycles (IDLE detect cycle + 32 RUN).
- Sign rules (div_signed=1):
  - Quotient is negated if src1[31]^src2[31].
  - Remainder takes src1's sign.
- Divisor 0: no iteration; IDLE goes straight to DONE in one cycle (stall 1 cycle). Result is LO=32'hFFFF_FFFF, HI=src1.
- MFHI/MFLO in the instruction right after a div reads the new HI/LO, because the write occurs on DONE exit.
- A div instruction never has data_ram_en or rf_we set; the decoder guarantees this and the block does not check it.
- rst in any state → IDLE, stallreq=0, HI/LO=0, partial result discarded.

Optional Feature:
- EX_MUL_EN defined:
  - alu_op 14/15 compute a 64-bit signed/unsigned product combinationally.
  - HI={prod[63:32]}, LO={prod[31:0]} are written on the edge the instruction leaves EX (stall[2]=0).
  - ex_result=0; no stall.
- EX_MUL_EN undefined:
  - ops 14/15 behave as NOP: ex_result=0 and HI/LO unchanged.
  - rf_we is still passed through as given.

Test Plan:
- Reset held 2 cycles, then ADD with src1=5, src2=7 loaded → ex_result=12; bus[75:44]=pc; data_sram_en=0.
- stall=6'b000111 with valid SUB in ID → EX register bubbles next cycle; ex_to_mem_bus=0.
- Store: data_ram_en=1, wen=4'hF, ADD src1=0x1000, src2=4, st_data=0xDEADBEEF → addr 0x1004, wdata 0xDEADBEEF, wen 0xF, same cycle as register load.
- Signed div: src1=-7 (0xFFFFFFF9), src2=2, div_en=1, div_signed=1 → stallreq high 33 cycles. Then MFLO → 0xFFFFFFFD (-3); MFHI → 0xFFFFFFFF (-1).
- Divide by zero: src1=0x1234, src2=0 → stallreq high 1 cycle. Then MFLO → 0xFFFFFFFF; MFHI → 0x1234.
- With EX_MUL_EN: MULTU with 0xFFFFFFFF × 2 → HI=1, LO=0xFFFFFFFE. Without EX_MUL_EN: HI/LO unchanged.

Source files
------------

// File: rtl/ex_stage.sv
// ex_stage: execute stage (ALU/shift/LUI/MFHI/MFLO, data-SRAM request, 32-cycle divider into HI/LO; define EX_MUL_EN for MULT/MULTU)
module ex_stage #(
  parameter int STALL_W  = 6,
  parameter int ID_EX_W  = 146,
  parameter int EX_MEM_W = 76
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STALL_W-1:0]  stall,
  input  logic [ID_EX_W-1:0]  id_to_ex_bus,
  output logic [EX_MEM_W-1:0] ex_to_mem_bus,
  output logic                data_sram_en,
  output logic [3:0]          data_sram_wen,
  output logic [31:0]         data_sram_addr,
  output logic [31:0]         data_sram_wdata,
  output logic                stallreq_for_ex
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;
  logic [ID_EX_W-1:0] id_ex_r;
  logic [31:0] pc, src1, src2, st_data, ex_result, hi, lo;
  logic [3:0] alu_op, data_ram_wen;
  logic data_ram_en, sel_rf_res, rf_we, div_en, div_signed;
  logic [4:0] rf_waddr, sh, cnt;
  div_state_t state, state_n;
  logic [31:0] q, r, d, abs1, abs2;
  logic neg_q, neg_r, div_zero;
  logic [32:0] r_sh, diff;

  always_ff @(posedge clk)
    if (rst || (stall[2] && !stall[3])) id_ex_r <= '0;
    else if (!stall[2]) id_ex_r <= id_to_ex_bus;

  assign {pc, alu_op, src1, src2, st_data, data_ram_en, data_ram_wen,
          sel_rf_res, rf_we, rf_waddr, div_en, div_signed} = id_ex_r;
  assign sh = src1[4:0];

`ifdef EX_MUL_EN
  logic [63:0] prod;
  logic mul_wr;
  assign prod = alu_op[0] ? {32'b0, src1} * {32'b0, src2}
                          : {{32{src1[31]}}, src1} * {{32{src2[31]}}, src2};
  assign mul_wr = alu_op[3:1] == 3'b111 && !stall[2];
`endif

  always_comb begin
    ex_result = '0;
    case (alu_op)
      4'd0:    ex_result = src1 + src2;
      4'd1:    ex_result = src1 - src2;
      4'd2:    ex_result = src1 & src2;
      4'd3:    ex_result = src1 | src2;
      4'd4:    ex_result = src1 ^ src2;
      4'd5:    ex_result = ~(src1 | src2);
      4'd6:    ex_result = {31'b0, $signed(src1) < $signed(src2)};
      4'd7:    ex_result = {31'b0, src1 < src2};
      4'd8:    ex_result = src2 << sh;
      4'd9:    ex_result = src2 >> sh;
      4'd10:   ex_result = $signed(src2) >>> sh;
      4'd11:   ex_result = {src2[15:0], 16'h0};
      4'd12:   ex_result = hi;
      4'd13:   ex_result = lo;
      default: ex_result = '0;
    endcase
  end

  assign ex_to_mem_bus   = {pc, data_ram_en, data_ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result};
  assign data_sram_en    = data_ram_en;
  assign data_sram_wen   = data_ram_wen;
  assign data_sram_addr  = ex_result;
  assign data_sram_wdata = st_data;

  assign abs1     = div_signed && src1[31] ? -src1 : src1;
  assign abs2     = div_signed && src2[31] ? -src2 : src2;
  assign div_zero = src2 == '0;
  assign r_sh     = {r, q[31]};
  assign diff     = r_sh - {1'b0, d};

  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;

  always_comb begin
    state_n = state == IDLE ? (div_en ? (div_zero ? DONE : RUN) : IDLE)
            : state == RUN  ? (cnt == 5'd31 ? DONE : RUN)
            : (stall[2] ? DONE : IDLE);
    stallreq_for_ex = (state == IDLE && div_en) || state == RUN;
  end

  always_ff @(posedge clk)
    if (rst) begin
      cnt   <= '0;
      q     <= '0;
      r     <= '0;
      d     <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      if (state == IDLE && div_en) begin
        q     <= div_zero ? '1 : abs1;
        r     <= div_zero ? src1 : '0;
        d     <= abs2;
        neg_q <= !div_zero && div_signed && (src1[31] ^ src2[31]);
        neg_r <= !div_zero && div_signed && src1[31];
        cnt   <= '0;
      end else if (state == RUN) begin
        q   <= {q[30:0], ~diff[32]};
        r   <= diff[32] ? r_sh[31:0] : diff[31:0];
        cnt <= cnt + 5'd1;
      end
`ifdef EX_MUL_EN
      if (mul_wr) {hi, lo} <= prod;
`endif
      if (state == DONE && !stall[2]) begin
        lo <= neg_q ? -q : q;
        hi <= neg_r ? -r : r;
      end
    end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed stimulus with a reference model of ex_stage checked every cycle
module tb_ex_stage;
  logic clk = 1'b0, rst;
  logic [5:0] stall, stall_force;
  logic [145:0] id_bus;
  logic [75:0] ex_to_mem_bus;
  logic data_sram_en, stallreq_for_ex;
  logic [3:0] data_sram_wen;
  logic [31:0] data_sram_addr, data_sram_wdata;
  int n_chk = 0, n_pass = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;
  assign stall = stall_force | (stallreq_for_ex ? 6'b000111 : 6'b0);

  ex_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .id_to_ex_bus(id_bus),
    .ex_to_mem_bus(ex_to_mem_bus), .data_sram_en(data_sram_en),
    .data_sram_wen(data_sram_wen), .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata), .stallreq_for_ex(stallreq_for_ex)
  );

  task automatic check(input string name, input logic [75:0] act, input logic [75:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [145:0] mk(input logic [31:0] pc, input logic [3:0] op,
      input logic [31:0] a, b, st, input logic en, input logic [3:0] wen,
      input logic sel, we, input logic [4:0] wa, input logic de, ds);
    return {pc, op, a, b, st, en, wen, sel, we, wa, de, ds};
  endfunction

  function automatic logic [31:0] exp_res(input logic [145:0] b, input logic [31:0] h, l);
    logic [31:0] a = b[109:78], c = b[77:46];
    int s = int'(b[82:78]);
    int sc = c;
    case (b[113:110])
      4'd0:  return a + c;
      4'd1:  return a - c;
      4'd2:  return a & c;
      4'd3:  return a | c;
      4'd4:  return a ^ c;
      4'd5:  return ~(a | c);
      4'd6:  return (int'(a) < int'(c)) ? 32'd1 : 32'd0;
      4'd7:  return (a < c) ? 32'd1 : 32'd0;
      4'd8:  return c << s;
      4'd9:  return c >> s;
      4'd10: return sc >>> s;
      4'd11: return c * 32'h10000;
      4'd12: return h;
      4'd13: return l;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [63:0] div_m(input logic [31:0] a, c, input logic sg);
    int sa = a, sc = c;
    if (c == 0) return {a, 32'hFFFF_FFFF};
    if (sg) return {32'(sa % sc), 32'(sa / sc)};
    return {a % c, a / c};
  endfunction

  function automatic logic [63:0] mul_m(input logic [31:0] a, c, input logic sg);
    longint sa = $signed(a), sc = $signed(c);
    if (sg) return 64'(sa * sc);
    return {32'b0, a} * {32'b0, c};
  endfunction

  // reference model: what EX holds, HI/LO, and the outstanding divide
  logic [145:0] ex_m;
  logic [31:0] hi_m, lo_m, pq, pr;
  int left_m;
  bit pend_m;
  always @(posedge clk) begin
    if (rst) begin
      ex_m <= '0; hi_m <= '0; lo_m <= '0; left_m <= 0; pend_m <= 1'b0;
    end else begin
      ex_m <= (stall[2] && !stall[3]) ? '0 : !stall[2] ? id_bus : ex_m;
      if (!pend_m && ex_m[1]) begin
        pend_m <= 1'b1;
        left_m <= (ex_m[77:46] == 0) ? 0 : 32;
        {pr, pq} <= div_m(ex_m[109:78], ex_m[77:46], ex_m[0]);
      end else if (left_m > 0) left_m <= left_m - 1;
      else if (pend_m && !stall[2]) begin
        hi_m <= pr; lo_m <= pq; pend_m <= 1'b0;
      end
`ifdef EX_MUL_EN
      if (!stall[2] && ex_m[113:111] == 3'b111)
        {hi_m, lo_m} <= mul_m(ex_m[109:78], ex_m[77:46], ex_m[110] == 1'b0);
`endif
    end
  end

  always @(negedge clk) if (chk_en) begin
    check("bus", ex_to_mem_bus, {ex_m[145:114], ex_m[13], ex_m[12:9], ex_m[8], ex_m[7], ex_m[6:2], exp_res(ex_m, hi_m, lo_m)});
    check("sram_en", data_sram_en, ex_m[13]);
    check("sram_wen", data_sram_wen, ex_m[12:9]);
    check("sram_addr", data_sram_addr, exp_res(ex_m, hi_m, lo_m));
    check("sram_wdata", data_sram_wdata, ex_m[45:14]);
    check("stallreq", stallreq_for_ex, (!pend_m && ex_m[1]) || left_m > 0);
  end

  task automatic issue(input logic [145:0] b);
    bit acc;
    int n = 0;
    id_bus = b;
    forever begin
      acc = !stall[2];
      @(posedge clk); #2;
      if (acc) break;
      if (++n > 200) begin
        n_chk++;
        $display("FAIL issue_timeout: still stalled after %0d cycles, required acceptance", n);
        break;
      end
    end
    id_bus = '0;
  endtask

  task automatic count_stall(input string name, input int exp);
    int n = 0;
    while (stallreq_for_ex && n < 100) begin
      n++;
      @(posedge clk); #2;
    end
    check(name, n, exp);
  endtask

  logic [3:0]  t_op [12] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11};
  logic [31:0] t_a  [12] = '{32'hFFFFFFFF, 32'd3, 32'hF0F0, 32'hF0F0, 32'hF0F0, 32'd0, 32'hFFFFFFFF,
                             32'hFFFFFFFF, 32'd4, 32'd4, 32'd4, 32'd0};
  logic [31:0] t_b  [12] = '{32'd2, 32'd5, 32'hFF00, 32'hFF00, 32'hFF00, 32'd0, 32'd1, 32'd1, 32'd1,
                             32'h80000000, 32'h80000000, 32'h1234};
  logic [31:0] t_e  [12] = '{32'd1, 32'hFFFFFFFE, 32'hF000, 32'hFFF0, 32'h0FF0, 32'hFFFFFFFF, 32'd1,
                             32'd0, 32'd16, 32'h08000000, 32'hF8000000, 32'h12340000};

  localparam logic [3:0] MFHI = 4'd12, MFLO = 4'd13;

  initial begin
    rst = 1'b1; stall_force = '0; id_bus = '0;
    repeat (2) @(posedge clk);
    #2;
    chk_en = 1'b1;
    check("reset_bus", ex_to_mem_bus, 76'd0);
    check("reset_stallreq", stallreq_for_ex, 1'b0);
    rst = 1'b0;

    issue(mk(32'h100, 4'd0, 32'd5, 32'd7, 32'd0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0));
    check("add_result", ex_to_mem_bus[31:0], 32'd12);
    check("add_pc", ex_to_mem_bus[75:44], 32'h100);
    check("add_sram_en", data_sram_en, 1'b0);

    id_bus = mk(32'h104, 4'd1, 32'd20, 32'd3, 32'd0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0);
    stall_force = 6'b000111;
    @(posedge clk); #2;
    check("bubble_bus", ex_to_mem_bus, 76'd0);
    stall_force = '0;
    issue(id_bus);
    check("sub_result", ex_to_mem_bus[31:0], 32'd17);

    issue(mk(32'h108, 4'd0, 32'h1000, 32'd4, 32'hDEADBEEF, 1'b1, 4'hF, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0));
    check("store_addr", data_sram_addr, 32'h1004);
    check("store_wdata", data_sram_wdata, 32'hDEADBEEF);
    check("store_wen", data_sram_wen, 4'hF);
    check("store_en", data_sram_en, 1'b1);

    for (int i = 0; i < 12; i++) begin
      issue(mk(32'h200 + 32'(i * 4), t_op[i], t_a[i], t_b[i], 32'd0, 1'b0, 4'h0, 1'b0, 1'b1, 5'(i + 1), 1'b0, 1'b0));
      check($sformatf("alu_op%0d", t_op[i]), ex_to_mem_bus[31:0], t_e[i]);
    end

    issue(mk(32'h300, 4'd0, 32'hFFFFFFF9, 32'd2, 32'd0, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1));
    id_bus = mk(32'h304, MFLO, 32'd0, 32'd0, 32'd0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0);
    count_stall("sdiv_stall_cycles", 33);
    @(posedge clk); #2;
    check("sdiv_lo", ex_to_mem_bus[31:0], 32'hFFFFFFFD);
    issue(mk(32'h308, MFHI, 32'd0, 32'd0, 32'd0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0));
    check("sdiv_hi", ex_to_mem_bus[31:0], 32'hFFFFFFFF);

    issue(mk(32'h400, 4'd0, 32'h1234, 32'd0, 32'd0, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0));
    id_bus = mk(32'h404, MFLO, 32'd0, 32'd0, 32'd0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0);
    count_stall("div0_stall_cycles", 1);
    @(posedge clk); #2;
    check("div0_lo", ex_to_mem_bus[31:0], 32'hFFFFFFFF);
    issue(mk(32'h408, MFHI, 32'd0, 32'd0, 32'd0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0));
    check("div0_hi", ex_to_mem_bus[31:0], 32'h1234);

    issue(mk(32'h500, 4'd0, 32'd100, 32'd7, 32'd0, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0));
    id_bus = mk(32'h504, MFLO, 32'd0, 32'd0, 32'd0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0);
    count_stall("udiv_stall_cycles", 33);
    stall_force = 6'b000100;
    repeat (2) @(posedge clk);
    #2;
    check("udiv_hold_stallreq", stallreq_for_ex, 1'b0);
    stall_force = '0;
    @(posedge clk); #2;
    check("udiv_lo", ex_to_mem_bus[31:0], 32'd14);
    issue(mk(32'h508, MFHI, 32'd0, 32'd0, 32'd0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0));
    check("udiv_hi", ex_to_mem_bus[31:0], 32'd2);

    issue(mk(32'h600, 4'd15, 32'hFFFFFFFF, 32'd2, 32'd0, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0));
    check("multu_result", ex_to_mem_bus[31:0], 32'd0);
    issue(mk(32'h604, MFHI, 32'd0, 32'd0, 32'd0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0));
`ifdef EX_MUL_EN
    check("multu_hi", ex_to_mem_bus[31:0], 32'd1);
`else
    check("multu_hi", ex_to_mem_bus[31:0], 32'd2);
`endif
    issue(mk(32'h608, MFLO, 32'd0, 32'd0, 32'd0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0));
`ifdef EX_MUL_EN
    check("multu_lo", ex_to_mem_bus[31:0], 32'hFFFFFFFE);
`else
    check("multu_lo", ex_to_mem_bus[31:0], 32'd14);
`endif

    issue(mk(32'h700, 4'd0, 32'hFFFFFFF9, 32'd2, 32'd0, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1));
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    check("rst_stallreq", stallreq_for_ex, 1'b0);
    issue(mk(32'h704, MFHI, 32'd0, 32'd0, 32'd0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0));
    check("rst_hi", ex_to_mem_bus[31:0], 32'd0);
    issue(mk(32'h708, MFLO, 32'd0, 32'd0, 32'd0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0));
    check("rst_lo", ex_to_mem_bus[31:0], 32'd0);

    repeat (3) @(posedge clk);
    #2;
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
